shift_reg_ctrl: RTL and testbench
=================================

// Module: shift_reg_ctrl
// PURPOSE
//   Sequencer for an N-bit serial-in/parallel-out shift register (D, CE, async active-low RSTN, Q[N-1:0]).
//   Accepts a parallel word over a valid/ready handshake and serialises it MSB-first into the register's D/CE.
//   Once all N bits are shifted in, captures the register's Q and presents it over a valid/ready output handshake.
//   Sits between a word-level producer/consumer and the shift register; also owns the register's clear.
// PARAMETERS
//   N    8  register width in bits; N >= 2 required
//   DW   8  width of DIV input (used only with SHIFT_CTRL_DIV_EN)
// PORTS
//   CLK        in   1   clock; all logic on posedge
//   RST        in   1   synchronous active-high reset
//   IN_VALID   in   1   DIN valid
//   IN_READY   out  1   controller can accept DIN; high only in IDLE and while RST low
//   DIN        in   N   parallel word to serialise
//   ABORT      in   1   synchronous cancel of the current transfer
//   SD         out  1   serial data to the shift register's D
//   SCE        out  1   clock enable to the shift register's CE
//   SRSTN      out  1   active-low clear to the shift register's RSTN (registered)
//   SQ         in   N   shift register's Q
//   OUT_VALID  out  1   DOUT valid
//   OUT_READY  in   1   consumer accepts DOUT
//   DOUT       out  N   captured SQ
//   BUSY       out  1   state != IDLE
//   DIV        in   DW  bit-period divider (port exists only with SHIFT_CTRL_DIV_EN)
// BEHAVIOUR
//   Reset (RST high at an edge): state IDLE; SD=0, SCE=0, SRSTN=0, OUT_VALID=0, DOUT=0, BUSY=0, bit count=0.
//     IN_READY=0 while RST high. SRSTN returns to 1 in the first cycle after RST deasserts.
//   States: IDLE -> SHIFT -> CAPT -> DONE -> IDLE.
//   IDLE: IN_VALID&&IN_READY at an edge latches DIN into a shadow register, clears count, enters SHIFT.
//   SHIFT: SCE=1 and SD=shadow[N-1] every cycle; each edge shifts the shadow left and increments count.
//     After N SCE cycles, enter CAPT. SD/SCE are registered (no combinational paths from inputs).
//   CAPT: one cycle with SCE=0 so that SQ reflects the last shifted bit; edge latches DOUT<=SQ and enters DONE.
//   DONE: OUT_VALID=1; DOUT held stable; OUT_VALID&&OUT_READY at an edge enters IDLE.
//   Latency (accept cycle = 0): SCE high in cycles 1..N, CAPT in cycle N+1, OUT_VALID first high in cycle N+2.
//   Back-to-back: IN_READY rises in the cycle after the output handshake (one bubble). No overlapping transfers.
//   ABORT (any state other than IDLE): next cycle state=IDLE, SCE=0, SD=0, OUT_VALID=0, SRSTN=0 for exactly
//     one cycle; DOUT keeps its last value. ABORT in IDLE with IN_VALID high: abort wins, no accept, SRSTN pulses.
//   RST mid-transfer: identical to the reset values above; any partial transfer is discarded.
//   Count width $clog2(N+1); count never exceeds N; shadow shift fills with 0.
//   SD=0 whenever SCE=0.
// CONFIGURATION
//   SHIFT_CTRL_DIV_EN defined: DIV port present; DIV sampled at accept. Each bit period lasts DIV+1 cycles;
//     SD is stable for the whole period; SCE=1 only in the last cycle of each period. DIV=0 gives default timing.
//     Latency: OUT_VALID first high in cycle N*(DIV+1)+2. ABORT still takes effect on the next cycle.
//   SHIFT_CTRL_DIV_EN undefined: no DIV port; one bit per cycle, as in BEHAVIOUR.
// STRUCTURE
//   Package shift_ctrl_pkg: state enum typedef (IDLE, SHIFT, CAPT, DONE); count-width function.
//   Sub-module shift_ctrl_bit_timer: DW-bit down-counter producing the end-of-bit strobe.
//     Instantiated only under SHIFT_CTRL_DIV_EN; without the macro, the strobe is constant 1.
// TESTING (bench loops SD/SCE/SRSTN/SQ to a real N=8 shift register)
//   1 RST high 3 cycles -> all outputs 0, SRSTN=0, IN_READY=0; release -> IN_READY=1, SRSTN=1, BUSY=0.
//   2 DIN=8'hA5, OUT_READY=1 -> SD=1,0,1,0,0,1,0,1 on 8 SCE cycles (1..8); OUT_VALID in cycle 10; DOUT=8'hA5.
//   3 DIN=8'h81, OUT_READY=0 for 5 cycles -> OUT_VALID/DOUT=8'h81 held; IN_READY=0; new IN_VALID ignored.
//   4 ABORT after 3 SCE cycles -> next cycle SCE=0, SRSTN=0 one cycle, IDLE, no OUT_VALID;
//     next DIN=8'h3C -> DOUT=8'h3C.
//   5 IN_VALID held, DIN=8'hFF then 8'h00 -> second accepted one cycle after first output handshake;
//     DOUT=8'hFF then 8'h00.
//   6 SHIFT_CTRL_DIV_EN, DIV=2, DIN=8'h5A -> each SD bit held 3 cycles; SCE on every 3rd; OUT_VALID in cycle 26;
//     DOUT=8'h5A.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
//   Shared types and helpers for the shift-register sequencer (shift_reg_ctrl)
//   and its optional bit-period timer (shift_ctrl_bit_timer).
//   Contents:
//     state_e    - sequencer state: IDLE -> SHIFT -> CAPT -> DONE -> IDLE
//     cnt_width  - width of a counter that must hold the values 0..n
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bits needed to count from 0 up to and including n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 32'd1);
    endfunction

endpackage

// File: rtl/shift_ctrl_bit_timer.sv
// -----------------------------------------------------------------------------
// shift_ctrl_bit_timer
//   DW-bit down-counter that stretches each serial bit to DIV+1 clock cycles.
//   Only present when SHIFT_CTRL_DIV_EN is defined; otherwise the sequencer
//   ends every bit period on every cycle and this file contributes nothing.
//   Ports:
//     clk_i       in   1   clock, posedge
//     rst_i       in   1   synchronous active-high reset
//     load_i      in   1   word accepted: sample div_i and start the first period
//     run_i       in   1   sequencer is shifting; count down / reload
//     div_i       in   DW  divider sampled on load_i
//     end_o       out  1   current cycle is the last cycle of a bit period
//     end_next_o  out  1   value end_o will have in the next cycle
// -----------------------------------------------------------------------------
`ifdef SHIFT_CTRL_DIV_EN
module shift_ctrl_bit_timer #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          run_i,
    input  logic [DW-1:0] div_i,
    output logic          end_o,
    output logic          end_next_o
);
    localparam logic [DW-1:0] TMR_ONE = DW'(1);

    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] tmr_q, tmr_d;

    // Next-state: load on accept, otherwise count down and reload at zero.
    always_comb begin
        div_d = div_q;
        tmr_d = tmr_q;
        if (load_i) begin
            div_d = div_i;
            tmr_d = div_i;
        end else if (run_i) begin
            if (tmr_q == {DW{1'b0}}) begin
                tmr_d = div_q;
            end else begin
                tmr_d = tmr_q - TMR_ONE;
            end
        end else begin
            tmr_d = tmr_q;
        end
    end

    // Divider and timer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= {DW{1'b0}};
            tmr_q <= {DW{1'b0}};
        end else begin
            div_q <= div_d;
            tmr_q <= tmr_d;
        end
    end

    assign end_o      = (tmr_q == {DW{1'b0}});
    // Lets the sequencer register SCE one cycle ahead of the period end.
    assign end_next_o = (tmr_d == {DW{1'b0}});

endmodule
`endif

// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//   Sequencer for an N-bit serial-in/parallel-out shift register. Accepts a
//   word over valid/ready, shifts it MSB-first into the register (SD/SCE),
//   captures the register's Q once all N bits are in and offers it over
//   valid/ready. Also drives the register's active-low clear.
//   Optional feature macro: SHIFT_CTRL_DIV_EN (adds div_i; each bit lasts
//   DIV+1 cycles with SCE only in the last cycle of the period).
//   Ports:
//     clk_i, rst_i          clock / synchronous active-high reset
//     in_valid_i/in_ready_o input handshake, din_i = word to serialise
//     abort_i               synchronous cancel of the current transfer
//     sd_o, sce_o, srstn_o  shift register D, CE, RSTN (all registered)
//     sq_i                  shift register Q
//     out_valid_o/out_ready_i output handshake, dout_o = captured Q
//     busy_o                sequencer not idle
//     div_i                 bit-period divider (SHIFT_CTRL_DIV_EN only)
// -----------------------------------------------------------------------------
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [N-1:0]  din_i,
    input  logic          abort_i,
    output logic          sd_o,
    output logic          sce_o,
    output logic          srstn_o,
    input  logic [N-1:0]  sq_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [N-1:0]  dout_o,
`ifdef SHIFT_CTRL_DIV_EN
    input  logic [DW-1:0] div_i,
`endif
    output logic          busy_o
);
    localparam int unsigned   CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 32'd1);

    // N >= 2 and DW >= 1 are required; this block only keeps both in view.
    if ((N < 32'd2) || (DW < 32'd1)) begin : g_param_range
    end

    state_e        state_q, state_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sd_q, sd_d;
    logic          sce_q, sce_d;
    logic          srstn_q, srstn_d;
    logic [N-1:0]  dout_q, dout_d;

    logic          in_ready_s;
    logic          accept_s;
    logic          run_s;
    logic          bit_end_s;
    logic          bit_end_next_s;

    // Abort takes priority over an accept in IDLE, so ready drops with it.
    assign in_ready_s = (state_q == IDLE) && !rst_i && !abort_i;
    assign accept_s   = in_valid_i && in_ready_s;
    assign run_s      = (state_q == SHIFT);

`ifdef SHIFT_CTRL_DIV_EN
    shift_ctrl_bit_timer #(
        .DW (DW)
    ) u_bit_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept_s),
        .run_i      (run_s),
        .div_i      (div_i),
        .end_o      (bit_end_s),
        .end_next_o (bit_end_next_s)
    );
`else
    // One bit per cycle: every cycle closes a bit period.
    assign bit_end_s      = 1'b1;
    assign bit_end_next_s = 1'b1;
`endif

    // Next-state, shadow, count and capture logic plus registered-output precompute.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        srstn_d  = 1'b1;
        if (abort_i) begin
            state_d = IDLE;
            srstn_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shadow_d = din_i;
                        cnt_d    = {CW{1'b0}};
                        state_d  = SHIFT;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_end_s) begin
                        shadow_d = {shadow_q[N-2:0], 1'b0};
                        cnt_d    = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = CAPT;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
                CAPT: begin
                    // SCE has been low for this cycle, so SQ holds the last bit.
                    dout_d  = sq_i;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // SD/SCE are computed from next-state values so they leave a flop.
        sce_d = (state_d == SHIFT) && bit_end_next_s;
        if (state_d == SHIFT) begin
            sd_d = shadow_d[N-1];
        end else begin
            sd_d = 1'b0;
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shadow_q <= {N{1'b0}};
            cnt_q    <= {CW{1'b0}};
            sd_q     <= 1'b0;
            sce_q    <= 1'b0;
            srstn_q  <= 1'b0;
            dout_q   <= {N{1'b0}};
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            sd_q     <= sd_d;
            sce_q    <= sce_d;
            srstn_q  <= srstn_d;
            dout_q   <= dout_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign sd_o        = sd_q;
    assign sce_o       = sce_q;
    assign srstn_o     = srstn_q;
    assign out_valid_o = (state_q == DONE);
    assign dout_o      = dout_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_ctrl
//   Drives shift_reg_ctrl with a real N=8 shift register on SD/SCE/SRSTN/SQ.
//   Expected behaviour comes from the transfer rules: bit c of a transfer
//   (period P = DIV+1) carries DIN[N-1-(c-1)/P], SCE is high when c is a
//   multiple of P, CAPT follows N*P shift cycles and DONE follows CAPT.
// -----------------------------------------------------------------------------
module tb_shift_reg_ctrl;
    localparam int N  = 8;
    localparam int DW = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [N-1:0]  din       = '0;
    logic          abort     = 1'b0;
    logic          sd;
    logic          sce;
    logic          srstn;
    logic [N-1:0]  sq;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  dout;
    logic          busy;
    logic [DW-1:0] div       = '0;

    int            n_cmp     = 0;
    int            n_mis     = 0;
    int            period    = 1;
    logic [N-1:0]  dout_exp  = '0;

    shift_reg_ctrl #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .din_i       (din),
        .abort_i     (abort),
        .sd_o        (sd),
        .sce_o       (sce),
        .srstn_o     (srstn),
        .sq_i        (sq),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .dout_o      (dout),
`ifdef SHIFT_CTRL_DIV_EN
        .div_i       (div),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // External shift register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            sq <= '0;
        end else if (sce) begin
            sq <= {sq[N-2:0], sd};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks for the cycle after an abort edge and the one that follows it.
    task automatic abort_checks();
        check("abort_sce",       32'(sce),       32'(0));
        check("abort_sd",        32'(sd),        32'(0));
        check("abort_srstn_lo",  32'(srstn),     32'(0));
        check("abort_busy",      32'(busy),      32'(0));
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_dout_kept", 32'(dout),      32'(dout_exp));
        step();
        check("abort_srstn_hi",  32'(srstn),     32'(1));
        check("abort_idle",      32'(busy),      32'(0));
        check("abort_in_ready",  32'(in_ready),  32'(1));
    endtask

    // One transfer starting in the current (idle) cycle as cycle 0.
    task automatic xfer(input logic [N-1:0] d, input int stall, input int abort_at,
                        input logic keep_valid, input logic [N-1:0] next_d);
        int total;
        int last;
        total = N * period;
        last  = total + 2 + stall;
        check("in_ready_idle", 32'(in_ready), 32'(1));
        check("busy_idle",     32'(busy),     32'(0));
        din       = d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = keep_valid;
        din      = next_d;
        for (int c = 1; c <= last; c++) begin
            if (c <= total) begin
                check("shift_sce",      32'(sce),      32'((c % period) == 0));
                check("shift_sd",       32'(sd),       32'(d[N-1-((c-1)/period)]));
                check("shift_in_ready", 32'(in_ready), 32'(0));
                check("shift_ov",       32'(out_valid), 32'(0));
            end else if (c == total + 1) begin
                check("capt_sce",  32'(sce),       32'(0));
                check("capt_sd",   32'(sd),        32'(0));
                check("capt_ov",   32'(out_valid), 32'(0));
                check("capt_sreg", 32'(sq),        32'(d));
            end else begin
                dout_exp = d;
                check("done_ov",       32'(out_valid), 32'(1));
                check("done_dout",     32'(dout),      32'(dout_exp));
                check("done_in_ready", 32'(in_ready),  32'(0));
                check("done_sce",      32'(sce),       32'(0));
            end
            check("busy", 32'(busy), 32'(1));
            if (c == abort_at) begin
                abort     = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                step();
                abort = 1'b0;
                abort_checks();
                return;
            end
            out_ready = (c == last);
            step();
        end
        out_ready = 1'b0;
        check("hs_ov",       32'(out_valid), 32'(0));
        check("hs_busy",     32'(busy),      32'(0));
        check("hs_in_ready", 32'(in_ready),  32'(1));
        check("hs_dout",     32'(dout),      32'(dout_exp));
    endtask

    initial begin
        logic [N-1:0] rd;
        int           ab;

        // 1: reset
        step();
        check("rst_sd",        32'(sd),        32'(0));
        check("rst_sce",       32'(sce),       32'(0));
        check("rst_srstn",     32'(srstn),     32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_dout",      32'(dout),      32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'(1));
        check("rel_busy",     32'(busy),     32'(0));
        step();
        check("rel_srstn",    32'(srstn),    32'(1));

        // 2: basic transfer, OUT_VALID in cycle N+2
        xfer(8'hA5, 0, -1, 1'b0, 8'h00);
        // 3: consumer stalls 5 cycles while a new IN_VALID is offered
        xfer(8'h81, 5, -1, 1'b1, 8'h42);
        in_valid = 1'b0;
        // 4: abort during the third SCE cycle, then a clean transfer
        xfer(8'h6E, 0, 3, 1'b0, 8'h00);
        xfer(8'h3C, 0, -1, 1'b0, 8'h00);
        // 5: IN_VALID held high across back-to-back words
        xfer(8'hFF, 0, -1, 1'b1, 8'h00);
        xfer(8'h00, 0, -1, 1'b0, 8'h00);

        // abort in IDLE with IN_VALID high: no accept, SRSTN pulses
        din      = 8'h99;
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        check("idle_abort_in_ready", 32'(in_ready), 32'(0));
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        abort_checks();

        // randomized transfers with random stalls and occasional aborts
        for (int i = 0; i < 24; i++) begin
            rd = N'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 2)) : -1;
            xfer(rd, int'($urandom_range(0, 3)), ab, 1'b0, 8'h00);
        end

        // reset in the middle of a transfer
        din      = 8'hC3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        dout_exp = '0;
        check("mid_rst_sce",       32'(sce),       32'(0));
        check("mid_rst_sd",        32'(sd),        32'(0));
        check("mid_rst_srstn",     32'(srstn),     32'(0));
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_dout",      32'(dout),      32'(0));
        check("mid_rst_busy",      32'(busy),      32'(0));
        check("mid_rst_in_ready",  32'(in_ready),  32'(0));
        rst = 1'b0;
        step();
        check("mid_rst_srstn_hi",  32'(srstn),     32'(1));
        xfer(8'h5C, 1, -1, 1'b0, 8'h00);

`ifdef SHIFT_CTRL_DIV_EN
        // 6: divided bit period, OUT_VALID in cycle N*(DIV+1)+2
        div    = 8'd2;
        period = 3;
        xfer(8'h5A, 0, -1, 1'b0, 8'h00);
        xfer(8'hB7, 0, 10, 1'b0, 8'h00);
        div    = 8'd0;
        period = 1;
        xfer(8'h1E, 0, -1, 1'b0, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
